gate_window_gen: RTL and testbench
==================================

// Module: gate_window_gen
// PURPOSE
//  Upstream of master_cntrl: turns the asynchronous external radar trigger into the gate_enable level
//  that enables the rx decimation strobe. Synchronises the trigger and detects its active edge.
//  Opens a sample window of programmable delay and width per trigger, configured over the serial
//  settings bus. Counts windows and flags triggers that arrive while a window is in progress.
// PARAMETERS
//  CNT_W      16      width of delay/width counters and window_count
//  SYNC_STG   2       trigger synchroniser depth (>=2)
//  ADDR_CTRL  7'd80   serial address of control reg (`FR_GATE_CTRL)
//  ADDR_DLY   7'd81   serial address of delay reg (`FR_GATE_DELAY)
//  ADDR_WID   7'd82   serial address of width reg (`FR_GATE_WIDTH)
// PORTS
//  master_clk    in   1      system clock (64 MHz)
//  reset_n       in   1      asynchronous, active-low reset
//  serial_addr   in   7      settings bus address
//  serial_data   in   32     settings bus data
//  serial_strobe in   1      settings bus write strobe, one cycle
//  trig_in       in   1      external trigger, asynchronous to master_clk
//  gate_enable   out  1      window level to master_cntrl
//  window_count  out  CNT_W  completed windows, wraps modulo 2^CNT_W
//  overrun       out  1      sticky: trigger edge seen while not IDLE
//  debug_bus     out  16     {state[1:0], sync_trig, trig_edge, gate_enable, overrun, 10'b0}
// BEHAVIOUR
//  Reset: all regs 0. gate_enable=0, window_count=0, overrun=0, state=IDLE.
//  Settings writes occur when serial_strobe && serial_addr==ADDR_x. Data is registered the same cycle.
//  CTRL bits:
//   [0] arm
//   [1] polarity (0 = rising edge, 1 = falling edge)
//   [2] bypass
//   [3] clr (write 1 clears overrun and window_count; self-clearing, not stored)
//  DELAY and WIDTH take data[CNT_W-1:0].
//  Sync: trig_in passes through SYNC_STG flops, then XOR polarity, then a 1-flop edge detect.
//   trig_edge is a 1-cycle pulse SYNC_STG+1 cycles after the trig_in transition.
//  Bypass=1: gate_enable <= sync_trig (polarity applied). FSM is held in IDLE and counters are frozen.
//  FSM, active only when arm=1 and bypass=0:
//   IDLE : on trig_edge latch shadow_dly<=DELAY and shadow_wid<=WIDTH, cnt<=0.
//          If WIDTH==0, stay in IDLE and do not increment window_count.
//          Else if DELAY==0, go to OPEN.
//          Else go to DELAY.
//   DELAY: cnt++ each cycle; when cnt==shadow_dly-1, cnt<=0 and go to OPEN.
//   OPEN : gate_enable=1 (registered); cnt++; when cnt==shadow_wid-1, go to IDLE,
//          gate_enable<=0, window_count++.
//  Timing: gate_enable rises SYNC_STG+2+DELAY cycles after the trig_in edge and stays high exactly
//   WIDTH cycles. master_cntrl adds a further 1-cycle latch.
//  Retrigger: a trig_edge in DELAY or OPEN is ignored for timing and sets overrun=1.
//  Register writes mid-window do not affect the current window (shadowed); they apply to the next trigger.
//  Disarm (arm write 0) mid-window: the FSM goes to IDLE next cycle, gate_enable=0 next cycle,
//   and window_count is not incremented.
//  clr coincident with overrun set or window_count increment: clr wins (result 0).
//  Async reset mid-window: gate_enable drops immediately; synchroniser flops also reset.
// STRUCTURE
//  Shared include fpga_regs: `FR_GATE_CTRL/`FR_GATE_DELAY/`FR_GATE_WIDTH addresses and CTRL bit
//   index constants. FSM state encodings are localparams: IDLE=2'd0, DELAY=2'd1, OPEN=2'd2.
//  Sub-module gate_sync holds the synchroniser, polarity XOR and edge detect
//   (ports: master_clk, reset_n, async_in, polarity, level, edge).
//  The top holds the settings regs, shadow regs, FSM and counters.
// TESTING
//  1. DELAY=10, WIDTH=100, arm=1, one rising trig_in -> gate_enable high 100 cycles starting
//     14 cycles after edge (SYNC_STG=2); window_count=1.
//  2. DELAY=0, WIDTH=1 -> single-cycle gate 4 cycles after edge.
//     WIDTH=0 -> gate never asserts, window_count unchanged.
//  3. Second trigger 50 cycles into a 100-cycle window -> window length unchanged, overrun=1;
//     CTRL write with clr -> overrun=0, window_count=0.
//  4. Write WIDTH=20 during an OPEN of WIDTH=100 -> current window 100, next window 20.
//  5. polarity=1 with falling edge -> window fires. Bypass=1 -> gate_enable follows trig_in with
//     3-cycle lag, window_count frozen.
//  6. Deassert reset_n mid-OPEN -> gate_enable=0 with no clock edge; after release all outputs 0;
//     a window_count 0xFFFF increment wraps to 0.

Source files
------------

// File: rtl/gate_window_gen_pkg.sv
// rtl/gate_window_gen_pkg.sv - shared addresses, control bits and state encodings for the gate window generator
package gate_window_gen_pkg;

  // Settings bus addresses of the gate window registers
  localparam logic [6:0] FR_GATE_CTRL  = 7'd80;
  localparam logic [6:0] FR_GATE_DELAY = 7'd81;
  localparam logic [6:0] FR_GATE_WIDTH = 7'd82;

  // Bit positions inside the control register
  localparam int CTRL_ARM_BIT = 0;
  localparam int CTRL_POL_BIT = 1;
  localparam int CTRL_BYP_BIT = 2;
  localparam int CTRL_CLR_BIT = 3;

  // Window FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_OPEN  = 2'd2;

  // Packs the observable internals into the 16-bit debug word
  function automatic logic [15:0] pack_debug(
    input logic [1:0] state,
    input logic       sync_trig,
    input logic       trig_edge,
    input logic       gate,
    input logic       ovr
  );
    return {state, sync_trig, trig_edge, gate, ovr, 10'b0};
  endfunction

endpackage

// File: rtl/gate_window_gen_sync.sv
// rtl/gate_window_gen_sync.sv - trigger synchroniser, polarity select and registered edge detect
module gate_sync
  import gate_window_gen_pkg::*;
#(
  parameter int SYNC_STG = 2
) (
  input  logic master_clk,
  input  logic reset_n,
  input  logic async_in,
  input  logic polarity,
  output logic level,
  output logic edge_pulse
);

  logic [SYNC_STG-1:0] r_sync;
  logic                r_level_d;
  logic                r_edge;
  logic                w_level;

  // Metastability chain: the last stage is the first one considered stable
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STG-2:0], async_in};
    end
  end

  // Polarity folds falling-edge triggering into the same rising-edge detector
  assign w_level = r_sync[SYNC_STG-1] ^ polarity;

  // Edge pulse is registered so it lands one cycle after the level
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level_d <= 1'b0;
      r_edge    <= 1'b0;
    end else begin
      r_level_d <= w_level;
      r_edge    <= w_level & ~r_level_d;
    end
  end

  assign level      = w_level;
  assign edge_pulse = r_edge;

endmodule

// File: rtl/gate_window_gen.sv
// rtl/gate_window_gen.sv - trigger-driven programmable delay/width gate window with window counter
module gate_window_gen
  import gate_window_gen_pkg::*;
#(
  parameter int         CNT_W     = 16,
  parameter int         SYNC_STG  = 2,
  parameter logic [6:0] ADDR_CTRL = FR_GATE_CTRL,
  parameter logic [6:0] ADDR_DLY  = FR_GATE_DELAY,
  parameter logic [6:0] ADDR_WID  = FR_GATE_WIDTH
) (
  input  logic             master_clk,
  input  logic             reset_n,
  input  logic [6:0]       serial_addr,
  input  logic [31:0]      serial_data,
  input  logic             serial_strobe,
  input  logic             trig_in,
  output logic             gate_enable,
  output logic [CNT_W-1:0] window_count,
  output logic             overrun,
  output logic [15:0]      debug_bus
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Settings registers
  logic             r_arm;
  logic             r_pol;
  logic             r_bypass;
  logic [CNT_W-1:0] r_delay;
  logic [CNT_W-1:0] r_width;

  // Per-window shadow copies, counters and outputs
  logic [CNT_W-1:0] r_shadow_dly;
  logic [CNT_W-1:0] r_shadow_wid;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_window_count;
  logic             r_gate;
  logic             r_overrun;
  logic [1:0]       r_state;

  logic             w_wr_ctrl;
  logic             w_wr_dly;
  logic             w_wr_wid;
  logic             w_clr;
  logic             w_active;
  logic             w_sync_trig;
  logic             w_trig_edge;
  logic             w_dly_last;
  logic             w_wid_last;
  logic [1:0]       w_next_state;
  logic             w_load_shadow;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_gate_next;
  logic             w_win_done;
  logic             w_overrun_set;
  logic             w_unused_data;

  assign w_wr_ctrl = serial_strobe && (serial_addr == ADDR_CTRL);
  assign w_wr_dly  = serial_strobe && (serial_addr == ADDR_DLY);
  assign w_wr_wid  = serial_strobe && (serial_addr == ADDR_WID);
  // clr acts only on the write strobe itself and is never stored
  assign w_clr     = w_wr_ctrl && serial_data[CTRL_CLR_BIT];
  assign w_active  = r_arm && !r_bypass;

  // Only the low CTRL bits and DELAY/WIDTH field carry meaning
  assign w_unused_data = ^serial_data;

  gate_sync #(
    .SYNC_STG (SYNC_STG)
  ) u_sync (
    .master_clk (master_clk),
    .reset_n    (reset_n),
    .async_in   (trig_in),
    .polarity   (r_pol),
    .level      (w_sync_trig),
    .edge_pulse (w_trig_edge)
  );

  // Settings bus write decode
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm    <= 1'b0;
      r_pol    <= 1'b0;
      r_bypass <= 1'b0;
      r_delay  <= '0;
      r_width  <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_arm    <= serial_data[CTRL_ARM_BIT];
        r_pol    <= serial_data[CTRL_POL_BIT];
        r_bypass <= serial_data[CTRL_BYP_BIT];
      end
      if (w_wr_dly) begin
        r_delay <= serial_data[CNT_W-1:0];
      end
      if (w_wr_wid) begin
        r_width <= serial_data[CNT_W-1:0];
      end
    end
  end

  assign w_dly_last = (r_cnt == (r_shadow_dly - ONE));
  assign w_wid_last = (r_cnt == (r_shadow_wid - ONE));

  // FSM state register
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state: disarm or bypass forces IDLE, abandoning any window in progress
  always_comb begin
    w_next_state = r_state;
    if (!w_active) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_trig_edge && (r_width != '0)) begin
            w_next_state = (r_delay == '0) ? ST_OPEN : ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (w_dly_last) begin
            w_next_state = ST_OPEN;
          end
        end
        ST_OPEN: begin
          if (w_wid_last) begin
            w_next_state = ST_IDLE;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: counter restarts on every state change, gate follows the next state
  always_comb begin
    w_load_shadow = w_active && (r_state == ST_IDLE) && w_trig_edge;
    w_win_done    = w_active && (r_state == ST_OPEN) && w_wid_last;
    w_overrun_set = w_trig_edge && (r_state != ST_IDLE);
    w_cnt_next    = '0;
    if ((w_next_state == r_state) && (r_state != ST_IDLE)) begin
      w_cnt_next = r_cnt + ONE;
    end
    w_gate_next = 1'b0;
    if (r_bypass) begin
      w_gate_next = w_sync_trig;
    end else begin
      w_gate_next = (w_next_state == ST_OPEN);
    end
  end

  // Window datapath: shadows freeze timing for the window just triggered
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow_dly <= '0;
      r_shadow_wid <= '0;
      r_cnt        <= '0;
      r_gate       <= 1'b0;
    end else begin
      if (w_load_shadow) begin
        r_shadow_dly <= r_delay;
        r_shadow_wid <= r_width;
      end
      r_cnt  <= w_cnt_next;
      r_gate <= w_gate_next;
    end
  end

  // Window counter and sticky overrun; a coincident clr takes priority
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_window_count <= '0;
      r_overrun      <= 1'b0;
    end else if (w_clr) begin
      r_window_count <= '0;
      r_overrun      <= 1'b0;
    end else begin
      if (w_win_done) begin
        r_window_count <= r_window_count + ONE;
      end
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign gate_enable  = r_gate;
  assign window_count = r_window_count;
  assign overrun      = r_overrun;
  assign debug_bus    = pack_debug(r_state, w_sync_trig, w_trig_edge, r_gate, r_overrun);

endmodule

// File: tb/tb_gate_window_gen.sv
// tb/tb_gate_window_gen.sv - directed self-checking bench for gate_window_gen
module tb_gate_window_gen;

  localparam logic [6:0] A_CTRL = 7'd80;
  localparam logic [6:0] A_DLY  = 7'd81;
  localparam logic [6:0] A_WID  = 7'd82;

  logic        clk;
  logic        reset_n;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic        trig_in;
  logic        gate_enable;
  logic [15:0] window_count;
  logic        overrun;
  logic [15:0] debug_bus;
  logic        gate_s;
  logic [3:0]  count_s;
  logic        overrun_s;
  logic [15:0] debug_s;

  int n_checks = 0;
  int n_fail   = 0;
  int rise;
  int len;

  gate_window_gen dut (
    .master_clk    (clk),
    .reset_n       (reset_n),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe),
    .trig_in       (trig_in),
    .gate_enable   (gate_enable),
    .window_count  (window_count),
    .overrun       (overrun),
    .debug_bus     (debug_bus)
  );

  gate_window_gen #(.CNT_W(4)) dut_s (
    .master_clk    (clk),
    .reset_n       (reset_n),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe),
    .trig_in       (trig_in),
    .gate_enable   (gate_s),
    .window_count  (count_s),
    .overrun       (overrun_s),
    .debug_bus     (debug_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [6:0] a, input logic [31:0] d);
    serial_addr   = a;
    serial_data   = d;
    serial_strobe = 1'b1;
    @(posedge clk);
    #1;
    serial_strobe = 1'b0;
  endtask

  task automatic run_window(input int max_cyc, input int lo_at, input int hi_at,
                            input int wr_at, input logic [6:0] wa, input logic [31:0] wd,
                            output int r, output int l);
    r = 0;
    l = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      if (k == lo_at) trig_in = 1'b0;
      if (k == hi_at) trig_in = 1'b1;
      if (k == wr_at) begin
        serial_addr   = wa;
        serial_data   = wd;
        serial_strobe = 1'b1;
      end else begin
        serial_strobe = 1'b0;
      end
      @(posedge clk);
      #1;
      if (gate_enable === 1'b1) begin
        if (r == 0) r = k;
        l++;
      end
    end
    serial_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    n_checks++; if (gate_enable !== 1'b0) begin n_fail++; $display("FAIL reset_gate: got %0b expected 0", gate_enable); end
    n_checks++; if (window_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", window_count); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    n_checks++; if (debug_bus !== 16'h0) begin n_fail++; $display("FAIL reset_debug: got %h expected 0000", debug_bus); end
    reset_n = 1'b1;
    idle(3);
  endtask

  task automatic test_basic_window();
    write_reg(A_DLY, 32'd10);
    write_reg(A_WID, 32'd100);
    write_reg(A_CTRL, 32'h1);
    trig_in = 1'b1;
    run_window(200, 0, 0, 0, 7'd0, 32'd0, rise, len);
    n_checks++; if (rise !== 14) begin n_fail++; $display("FAIL basic_rise: got %0d expected 14", rise); end
    n_checks++; if (len !== 100) begin n_fail++; $display("FAIL basic_len: got %0d expected 100", len); end
    n_checks++; if (window_count !== 16'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", window_count); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: got %0b expected 0", overrun); end
    trig_in = 1'b0;
    idle(6);
  endtask

  task automatic test_short_and_zero();
    write_reg(A_DLY, 32'd0);
    write_reg(A_WID, 32'd1);
    trig_in = 1'b1;
    run_window(30, 0, 0, 0, 7'd0, 32'd0, rise, len);
    n_checks++; if (rise !== 4) begin n_fail++; $display("FAIL short_rise: got %0d expected 4", rise); end
    n_checks++; if (len !== 1) begin n_fail++; $display("FAIL short_len: got %0d expected 1", len); end
    n_checks++; if (window_count !== 16'd2) begin n_fail++; $display("FAIL short_count: got %0d expected 2", window_count); end
    trig_in = 1'b0;
    idle(6);
    write_reg(A_WID, 32'd0);
    trig_in = 1'b1;
    run_window(30, 0, 0, 0, 7'd0, 32'd0, rise, len);
    n_checks++; if (len !== 0) begin n_fail++; $display("FAIL zero_len: got %0d expected 0", len); end
    n_checks++; if (window_count !== 16'd2) begin n_fail++; $display("FAIL zero_count: got %0d expected 2", window_count); end
    trig_in = 1'b0;
    idle(6);
  endtask

  task automatic test_overrun_clr();
    write_reg(A_DLY, 32'd10);
    write_reg(A_WID, 32'd100);
    trig_in = 1'b1;
    run_window(200, 20, 64, 0, 7'd0, 32'd0, rise, len);
    n_checks++; if (rise !== 14) begin n_fail++; $display("FAIL ovr_rise: got %0d expected 14", rise); end
    n_checks++; if (len !== 100) begin n_fail++; $display("FAIL ovr_len: got %0d expected 100", len); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %0b expected 1", overrun); end
    n_checks++; if (window_count !== 16'd3) begin n_fail++; $display("FAIL ovr_count: got %0d expected 3", window_count); end
    write_reg(A_CTRL, 32'h9);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL clr_overrun: got %0b expected 0", overrun); end
    n_checks++; if (window_count !== 16'd0) begin n_fail++; $display("FAIL clr_count: got %0d expected 0", window_count); end
    trig_in = 1'b0;
    idle(6);
  endtask

  task automatic test_shadow();
    trig_in = 1'b1;
    run_window(200, 0, 0, 50, A_WID, 32'd20, rise, len);
    n_checks++; if (len !== 100) begin n_fail++; $display("FAIL shadow_cur_len: got %0d expected 100", len); end
    n_checks++; if (window_count !== 16'd1) begin n_fail++; $display("FAIL shadow_count1: got %0d expected 1", window_count); end
    trig_in = 1'b0;
    idle(6);
    trig_in = 1'b1;
    run_window(100, 0, 0, 0, 7'd0, 32'd0, rise, len);
    n_checks++; if (rise !== 14) begin n_fail++; $display("FAIL shadow_next_rise: got %0d expected 14", rise); end
    n_checks++; if (len !== 20) begin n_fail++; $display("FAIL shadow_next_len: got %0d expected 20", len); end
    n_checks++; if (window_count !== 16'd2) begin n_fail++; $display("FAIL shadow_count2: got %0d expected 2", window_count); end
  endtask

  task automatic test_polarity_bypass();
    write_reg(A_CTRL, 32'h0);
    idle(6);
    write_reg(A_CTRL, 32'h3);
    idle(6);
    trig_in = 1'b0;
    run_window(100, 0, 0, 0, 7'd0, 32'd0, rise, len);
    n_checks++; if (rise !== 14) begin n_fail++; $display("FAIL pol_rise: got %0d expected 14", rise); end
    n_checks++; if (len !== 20) begin n_fail++; $display("FAIL pol_len: got %0d expected 20", len); end
    n_checks++; if (window_count !== 16'd3) begin n_fail++; $display("FAIL pol_count: got %0d expected 3", window_count); end
    write_reg(A_CTRL, 32'h4);
    idle(6);
    n_checks++; if (gate_enable !== 1'b0) begin n_fail++; $display("FAIL byp_idle_gate: got %0b expected 0", gate_enable); end
    trig_in = 1'b1;
    run_window(12, 6, 0, 0, 7'd0, 32'd0, rise, len);
    n_checks++; if (rise !== 3) begin n_fail++; $display("FAIL byp_lag: got %0d expected 3", rise); end
    n_checks++; if (len !== 5) begin n_fail++; $display("FAIL byp_len: got %0d expected 5", len); end
    n_checks++; if (window_count !== 16'd3) begin n_fail++; $display("FAIL byp_count: got %0d expected 3", window_count); end
  endtask

  task automatic test_disarm();
    write_reg(A_CTRL, 32'h1);
    idle(4);
    trig_in = 1'b1;
    run_window(40, 0, 0, 20, A_CTRL, 32'h0, rise, len);
    n_checks++; if (rise !== 14) begin n_fail++; $display("FAIL disarm_rise: got %0d expected 14", rise); end
    n_checks++; if (len !== 7) begin n_fail++; $display("FAIL disarm_len: got %0d expected 7", len); end
    n_checks++; if (window_count !== 16'd3) begin n_fail++; $display("FAIL disarm_count: got %0d expected 3", window_count); end
    n_checks++; if (debug_bus[15:14] !== 2'd0) begin n_fail++; $display("FAIL disarm_state: got %0d expected 0", debug_bus[15:14]); end
    trig_in = 1'b0;
    idle(6);
  endtask

  task automatic test_reset_mid_window();
    write_reg(A_CTRL, 32'h1);
    idle(4);
    trig_in = 1'b1;
    run_window(20, 0, 0, 0, 7'd0, 32'd0, rise, len);
    n_checks++; if (gate_enable !== 1'b1) begin n_fail++; $display("FAIL rst_pre_gate: got %0b expected 1", gate_enable); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (gate_enable !== 1'b0) begin n_fail++; $display("FAIL rst_async_gate: got %0b expected 0", gate_enable); end
    n_checks++; if (window_count !== 16'd0) begin n_fail++; $display("FAIL rst_async_count: got %0d expected 0", window_count); end
    n_checks++; if (debug_bus !== 16'h0) begin n_fail++; $display("FAIL rst_async_debug: got %h expected 0000", debug_bus); end
    idle(2);
    reset_n = 1'b1;
    idle(2);
    n_checks++; if (gate_enable !== 1'b0) begin n_fail++; $display("FAIL rst_post_gate: got %0b expected 0", gate_enable); end
    n_checks++; if (window_count !== 16'd0) begin n_fail++; $display("FAIL rst_post_count: got %0d expected 0", window_count); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_post_overrun: got %0b expected 0", overrun); end
  endtask

  task automatic test_wrap();
    trig_in = 1'b0;
    write_reg(A_DLY, 32'd0);
    write_reg(A_WID, 32'd1);
    write_reg(A_CTRL, 32'h1);
    idle(4);
    for (int i = 0; i < 15; i++) begin
      trig_in = 1'b1;
      idle(6);
      trig_in = 1'b0;
      idle(3);
    end
    n_checks++; if (count_s !== 4'hF) begin n_fail++; $display("FAIL wrap_small_full: got %0d expected 15", count_s); end
    n_checks++; if (window_count !== 16'd15) begin n_fail++; $display("FAIL wrap_main_15: got %0d expected 15", window_count); end
    trig_in = 1'b1;
    idle(6);
    trig_in = 1'b0;
    idle(3);
    n_checks++; if (count_s !== 4'h0) begin n_fail++; $display("FAIL wrap_small_zero: got %0d expected 0", count_s); end
    n_checks++; if (window_count !== 16'd16) begin n_fail++; $display("FAIL wrap_main_16: got %0d expected 16", window_count); end
    n_checks++; if ({gate_s, overrun_s, debug_s} !== 18'h0) begin n_fail++; $display("FAIL wrap_small_idle: got %h expected 0", {gate_s, overrun_s, debug_s}); end
  endtask

  initial begin
    reset_n       = 1'b0;
    serial_addr   = 7'd0;
    serial_data   = 32'd0;
    serial_strobe = 1'b0;
    trig_in       = 1'b0;
    test_reset();
    test_basic_window();
    test_short_and_zero();
    test_overrun_clr();
    test_shadow();
    test_polarity_bypass();
    test_disarm();
    test_reset_mid_window();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
